// File: rtl/comp.sv
// ---------------------------------------------------------------------------
// comp : multi-cycle RV32I-subset core with private 256-word unified memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comp #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] OUT_ADDR  = 32'd1000,
  parameter logic [31:0] HALT_ADDR = 32'd1004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oob_wen,
  input  logic [31:0] oob_wr_addr,
  input  logic [31:0] oob_wr_data,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [4:0]  rd,
  output logic [6:0]  imm1,
  output logic [31:0] x1,
  output logic [4:0]  state,
  output logic [31:0] out,
  output logic        outen,
  output logic        halt
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd1,
    S_EXEC   = 5'd2,
    S_LOAD   = 5'd3,
    S_HALTED = 5'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_q, out_d;
  logic        outen_q, outen_d;
  logic        halt_q, halt_d;
  logic [31:0] regs_q [32];
  logic [31:0] mem_q [MEM_WORDS];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] eff_addr, alu_b, alu_res;
  logic [4:0]  shamt;
  logic        br_taken;
  logic        rf_we, mem_we;
  logic [31:0] rf_wdata;
  logic        unused_ok;

  assign opc     = instr_q[6:0];
  assign rd_idx  = instr_q[11:7];
  assign f3      = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign rs1_v   = regs_q[rs1_idx];
  assign rs2_v   = regs_q[rs2_idx];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  assign eff_addr = rs1_v + ((opc == OPC_STORE) ? imm_s : imm_i);
  assign alu_b    = (opc == OPC_OP) ? rs2_v : imm_i;
  assign shamt    = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000:  alu_res = (opc == OPC_OP && instr_q[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu_res = rs1_v << shamt;
      3'b010:  alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_v < alu_b};
      3'b100:  alu_res = rs1_v ^ alu_b;
      3'b101:  alu_res = instr_q[30] ? 32'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'b110:  alu_res = rs1_v | alu_b;
      default: alu_res = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_v == rs2_v);
      3'b001:  br_taken = (rs1_v != rs2_v);
      3'b100:  br_taken = ($signed(rs1_v) <  $signed(rs2_v));
      3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110:  br_taken = (rs1_v <  rs2_v);
      3'b111:  br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    out_d    = out_q;
    outen_d  = 1'b0;
    halt_d   = halt_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_d = mem_q[pc_q[AW+1:2]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 32'd4;
        case (opc)
          OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
          OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          OPC_JAL: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4;
            pc_d  = pc_q + imm_j;
          end
          OPC_JALR: begin
            rf_we = 1'b1; rf_wdata = pc_q + 32'd4;
            pc_d  = (rs1_v + imm_i) & ~32'd1;
          end
          OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
          OPC_LOAD: begin
            state_d = S_LOAD;
            pc_d    = pc_q;
          end
          OPC_STORE: begin
            if (eff_addr == OUT_ADDR) begin
              outen_d = 1'b1;
              out_d   = rs2_v;
            end else if (eff_addr == HALT_ADDR) begin
              halt_d  = 1'b1;
              state_d = S_HALTED;
              pc_d    = pc_q;
            end else begin
              mem_we = 1'b1;
            end
          end
          OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; rf_wdata = alu_res; end
          default: ;
        endcase
      end
      // Address is recomputed here; rd is not written until this cycle.
      S_LOAD: begin
        rf_we    = 1'b1;
        rf_wdata = mem_q[eff_addr[AW+1:2]];
        pc_d     = pc_q + 32'd4;
        state_d  = S_FETCH;
      end
      S_HALTED: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      out_q   <= '0;
      outen_q <= 1'b0;
      halt_q  <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      out_q   <= out_d;
      outen_q <= outen_d;
      halt_q  <= halt_d;
      if (rf_we && rd_idx != 5'd0) regs_q[rd_idx] <= rf_wdata;
    end
  end

  // OOB write is last so it wins against a CPU store to the same word.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[eff_addr[AW+1:2]] <= rs2_v;
    if (oob_wen) mem_q[oob_wr_addr[AW-1:0]] <= oob_wr_data;
  end

  assign unused_ok = ^{oob_wr_addr[31:AW]};

  assign pc    = pc_q;
  assign op    = instr_q[6:0];
  assign rd    = instr_q[11:7];
  assign imm1  = instr_q[31:25];
  assign x1    = regs_q[1];
  assign state = state_q;
  assign out   = out_q;
  assign outen = outen_q;
  assign halt  = halt_q;

endmodule

`default_nettype wire

// File: tb/tb_comp.sv
// ---------------------------------------------------------------------------
// tb_comp : self-checking bench for comp, scoreboard of expected output words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_comp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        oob_wen = 1'b0;
  logic [31:0] oob_wr_addr = '0;
  logic [31:0] oob_wr_data = '0;
  logic [31:0] pc, x1, out;
  logic [6:0]  op, imm1;
  logic [4:0]  rd, state;
  logic        outen, halt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] prog [$];
  logic [31:0] sb   [$];

  comp dut (
    .clk(clk), .rst(rst), .oob_wen(oob_wen), .oob_wr_addr(oob_wr_addr),
    .oob_wr_data(oob_wr_data), .pc(pc), .op(op), .rd(rd), .imm1(imm1),
    .x1(x1), .state(state), .out(out), .outen(outen), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rdi, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rdi);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rdi, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rdi, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(imm, rs1, 3'b000, rdi, 7'b0010011);
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] halt_i();
    return sw(5'd0, 5'd0, 32'd1004);
  endfunction

  task automatic load_prog();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < prog.size(); i++) begin
      oob_wen = 1'b1; oob_wr_addr = i; oob_wr_data = prog[i];
      @(negedge clk);
    end
    oob_wen = 1'b0;
  endtask

  task automatic reset_and_check();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_state", {27'b0, state}, 32'd1);
    check_eq("rst_halt", {31'b0, halt}, 32'd0);
    check_eq("rst_outen", {31'b0, outen}, 32'd0);
    check_eq("rst_x1", x1, 32'd0);
    rst = 1'b1;
  endtask

  // Runs with rst released until halt or budget; every outen pops the scoreboard.
  task automatic run_prog(input int budget, output int cycles);
    bit halted = 1'b0;
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (outen) begin
        if (sb.size() == 0) check_eq("extra_outen", {31'b0, outen}, 32'd0);
        else check_eq("out", out, sb.pop_front());
      end
      if (halt) halted = 1'b1;
    end
    check_eq("halted", {31'b0, halt}, 32'd1);
    check_eq("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  found;

    // Output + halt
    prog = '{addi(1, 0, 5), sw(1, 0, 1000), halt_i()};
    load_prog();
    sb.push_back(32'd5);
    reset_and_check();
    run_prog(40, cyc);
    check_eq("halt_latency_le6", {31'b0, (cyc <= 6)}, 32'd1);
    check_eq("p1_x1", x1, 32'd5);
    repeat (3) @(negedge clk);
    check_eq("halted_state_sticky", {27'b0, state}, 32'd4);
    check_eq("no_outen_halted", {31'b0, outen}, 32'd0);

    // Loop / branch
    prog = '{addi(2, 0, 3), sw(2, 0, 1000), addi(2, 2, -1),
             enc_b(-8, 0, 2, 3'b001), halt_i()};
    load_prog();
    sb.push_back(32'd3); sb.push_back(32'd2); sb.push_back(32'd1);
    reset_and_check();
    run_prog(100, cyc);

    // ALU edge cases and signed/unsigned branches
    prog = '{addi(1, 0, -1),
             enc_i(28, 1, 3'b101, 3, 7'b0010011),
             enc_i(32'h400 | 28, 1, 3'b101, 4, 7'b0010011),
             enc_r(7'd0, 1, 0, 3'b011, 5),
             enc_r(7'd0, 1, 0, 3'b010, 6),
             enc_r(7'd32, 1, 0, 3'b000, 7),
             sw(3, 0, 1000), sw(4, 0, 1000), sw(5, 0, 1000), sw(6, 0, 1000), sw(7, 0, 1000),
             enc_b(8, 0, 1, 3'b100), halt_i(),
             enc_b(8, 1, 0, 3'b111), sw(4, 0, 1000), halt_i()};
    load_prog();
    sb.push_back(32'h0000000F); sb.push_back(32'hFFFFFFFF); sb.push_back(32'd1);
    sb.push_back(32'd0);        sb.push_back(32'd1);        sb.push_back(32'hFFFFFFFF);
    reset_and_check();
    run_prog(100, cyc);

    // Memory round-trip
    prog = '{{20'h12345, 5'd1, 7'b0110111}, addi(1, 1, 32'h678), addi(2, 0, 32'h200),
             sw(1, 2, 0), enc_i(0, 2, 3'b010, 9, 7'b0000011), sw(9, 0, 1000), halt_i()};
    load_prog();
    sb.push_back(32'h12345678);
    reset_and_check();
    run_prog(60, cyc);
    check_eq("mem_word128", dut.mem_q[128], 32'h12345678);

    // Control flow and x0
    prog = '{{20'hABCDE, 5'd1, 7'b0110111}, addi(0, 0, 7), sw(0, 0, 1000), sw(1, 0, 1000),
             {20'h00001, 5'd8, 7'b0010111}, enc_j(8, 7), addi(8, 0, 0),
             sw(7, 0, 1000), sw(8, 0, 1000),
             enc_i(45, 0, 3'b000, 10, 7'b1100111), halt_i(),
             sw(10, 0, 1000), halt_i()};
    load_prog();
    sb.push_back(32'd0); sb.push_back(32'hABCDE000); sb.push_back(32'd24);
    sb.push_back(32'h00001010); sb.push_back(32'd40);
    reset_and_check();
    run_prog(60, cyc);
    check_eq("lui_x1", x1, 32'hABCDE000);

    // Reset asserted during EXEC of the output store
    prog = '{addi(1, 0, 5), sw(1, 0, 1000), halt_i()};
    load_prog();
    reset_and_check();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (state == 5'd2 && pc == 32'd4) found = 1'b1;
    end
    check_eq("found_exec_sw", {31'b0, found}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_outen", {31'b0, outen}, 32'd0);
    check_eq("abort_pc", pc, 32'd0);
    check_eq("abort_state", {27'b0, state}, 32'd1);
    check_eq("abort_halt", {31'b0, halt}, 32'd0);
    check_eq("abort_mem_intact", dut.mem_q[1], prog[1]);
    sb.push_back(32'd5);
    reset_and_check();
    run_prog(40, cyc);
    check_eq("rerun_x1", x1, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
